// File: rtl/regfile_pkg.sv
// Shared types and helpers for the unified int/float register file.
// Indices 0..31 are integer registers, 32..63 are float registers.
package regfile_pkg;

    localparam int NREG     = 64;
    localparam int AW       = $clog2(NREG);
    localparam int INT_BASE = 0;
    localparam int FP_BASE  = 32;

    typedef logic [AW-1:0] reg_idx_t;

    // x0 is always zero; f0 is zero too when zero_fp0 is set
    function automatic logic is_zero_idx(
        input reg_idx_t idx,
        input logic     zero_fp0
    );
        return (idx[4:0] == 5'd0) &&
               (zero_fp0 || (idx[AW-1:5] == '0));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, reserve at issue,
// release on writeback, flush drops everything, registered pending count.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = regfile_pkg::NREG,
    parameter int NWR      = 2,
    parameter bit ZERO_FP0 = 1'b1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wb_en,
    input  logic [NWR*AW-1:0] wb_addr,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              flush,
    output logic              rsv_ok,
    output logic [NREG-1:0]   busy,
    output logic [AW:0]       busy_cnt
);

    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_cnt;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_cnt_nxt;
    logic            w_rsv_zero;
    logic            w_rsv_take;

    // Reserve is granted only against the current busy bit, so a release
    // landing in the same cycle cannot let a second owner in early.
    always_comb begin
        w_rsv_zero = is_zero_idx(reg_idx_t'(rsv_addr), ZERO_FP0);
        rsv_ok     = w_rsv_zero || !r_busy[rsv_addr];
        w_rsv_take = rsv_en && rsv_ok && !flush && !w_rsv_zero;
    end

    // Next busy vector: release first, then reserve (new owner wins), flush last
    always_comb begin
        w_busy_nxt = r_busy;
        for (int w = 0; w < NWR; w++) begin
            if (wb_en[w]) begin
                w_busy_nxt[wb_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (w_rsv_take) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
    end

    // Pending count is the popcount of the next state, so it cannot drift
    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    // Busy bits and count register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write->read bypass; the scoreboard
// supplies per-register pending state used for the read ready flags.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = regfile_pkg::NREG,
    parameter int NRD      = 3,
    parameter int NWR      = 2,
    parameter bit ZERO_FP0 = 1'b1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_ready,
    input  logic [NWR-1:0]      wb_en,
    input  logic [NWR*AW-1:0]   wb_addr,
    input  logic [NWR*XLEN-1:0] wb_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ok,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] w_busy;

    reg_scoreboard #(
        .NREG     (NREG),
        .NWR      (NWR),
        .ZERO_FP0 (ZERO_FP0)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .rsv_ok   (rsv_ok),
        .busy     (w_busy),
        .busy_cnt (busy_cnt)
    );

    // Storage; ports are visited in ascending order so the highest port wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '{default: '0};
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wb_en[w] &&
                    !is_zero_idx(reg_idx_t'(wb_addr[w*AW +: AW]), ZERO_FP0)) begin
                    r_regs[wb_addr[w*AW +: AW]] <= wb_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Per-port read: array value, then bypass (highest port last), zero overrides
    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data[p*XLEN +: XLEN] = r_regs[rd_addr[p*AW +: AW]];
            rd_ready[p]             = !w_busy[rd_addr[p*AW +: AW]];
            for (int w = 0; w < NWR; w++) begin
                if (wb_en[w] &&
                    (wb_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
                    rd_data[p*XLEN +: XLEN] = wb_data[w*XLEN +: XLEN];
                    rd_ready[p]             = 1'b1;
                end
            end
            if (is_zero_idx(reg_idx_t'(rd_addr[p*AW +: AW]), ZERO_FP0)) begin
                rd_data[p*XLEN +: XLEN] = '0;
                rd_ready[p]             = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table followed by random
// traffic checked against a behavioural model through an expectation queue.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int AW   = 6;
    localparam int NRD  = 3;
    localparam int NWR  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data, rd_data_nz;
    logic [NRD-1:0]      rd_ready, rd_ready_nz;
    logic [NWR-1:0]      wb_en;
    logic [NWR*AW-1:0]   wb_addr;
    logic [NWR*XLEN-1:0] wb_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ok, rsv_ok_nz;
    logic                flush;
    logic [AW:0]         busy_cnt, busy_cnt_nz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.ZERO_FP0(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.ZERO_FP0(1'b0)) dut_nz (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data_nz), .rd_ready(rd_ready_nz),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_nz),
        .flush(flush), .busy_cnt(busy_cnt_nz)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  wen;
        logic [5:0]  wa0;
        logic [31:0] wd0;
        logic [5:0]  wa1;
        logic [31:0] wd1;
        logic        ren;
        logic [5:0]  ra;
        logic        fl;
        logic [5:0]  r0, r1, r2;
        logic [31:0] e0, e1, e2;
        logic [2:0]  erdy;
        logic        eok;
        logic [6:0]  ecnt;
        logic [31:0] enz1;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e [3];
        logic [2:0]  erdy;
        logic        eok;
        logic [6:0]  ecnt;
        logic        chk_nz;
        logic [31:0] enz1;
    } exp_t;

    vec_t tbl[$];
    exp_t expq[$];

    // Behavioural model for the random phase (ZERO_FP0 = 1)
    logic [31:0] mregs [64];
    logic        mbusy [64];

    function automatic vec_t mk(
        string n, logic r, logic [1:0] wen,
        logic [5:0] wa0, logic [31:0] wd0,
        logic [5:0] wa1, logic [31:0] wd1,
        logic ren, logic [5:0] ra, logic fl,
        logic [5:0] r0, logic [5:0] r1, logic [5:0] r2,
        logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
        logic [2:0] erdy, logic eok, logic [6:0] ecnt,
        logic [31:0] enz1
    );
        vec_t v;
        v.name = n; v.rst = r; v.wen = wen;
        v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ren = ren; v.ra = ra; v.fl = fl;
        v.r0 = r0; v.r1 = r1; v.r2 = r2;
        v.e0 = e0; v.e1 = e1; v.e2 = e2;
        v.erdy = erdy; v.eok = eok; v.ecnt = ecnt; v.enz1 = enz1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst      = v.rst;
        wb_en    = v.wen;
        wb_addr  = {v.wa1, v.wa0};
        wb_data  = {v.wd1, v.wd0};
        rsv_en   = v.ren;
        rsv_addr = v.ra;
        flush    = v.fl;
        rd_addr  = {v.r2, v.r1, v.r0};
    endtask

    task automatic check_one(input string n, input string what,
                             input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", n, what, act, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t x;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue: no expectation available");
            return;
        end
        x = expq.pop_front();
        for (int p = 0; p < NRD; p++) begin
            check_one(x.name, $sformatf("rd_data[%0d]", p),
                      rd_data[p*XLEN +: XLEN], x.e[p]);
        end
        check_one(x.name, "rd_ready", 32'(rd_ready), 32'(x.erdy));
        check_one(x.name, "rsv_ok", 32'(rsv_ok), 32'(x.eok));
        check_one(x.name, "busy_cnt", 32'(busy_cnt), 32'(x.ecnt));
        if (x.chk_nz) begin
            check_one(x.name, "nz rd_data[1]", rd_data_nz[XLEN +: XLEN], x.enz1);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        exp_t x;
        @(posedge clk);
        #1;
        drive(v);
        x.name = v.name;
        x.e[0] = v.e0; x.e[1] = v.e1; x.e[2] = v.e2;
        x.erdy = v.erdy; x.eok = v.eok; x.ecnt = v.ecnt;
        x.chk_nz = 1'b1; x.enz1 = v.enz1;
        expq.push_back(x);
        #3;
        check_outputs();
    endtask

    function automatic logic mzero(input logic [5:0] a);
        return a[4:0] == 5'd0;
    endfunction

    task automatic rand_cycle(input int n);
        vec_t  v;
        exp_t  x;
        logic [5:0]  ra [3];
        logic [5:0]  wa [2];
        logic [31:0] wd [2];
        int cnt;
        v = mk($sformatf("rnd%0d", n), 1'b0, 2'($urandom_range(0, 3)),
               6'($urandom_range(0, 15)), $urandom,
               6'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)),
               ($urandom_range(0, 15) == 0),
               6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
               6'($urandom_range(32, 47)),
               '0, '0, '0, '0, 1'b0, '0, '0);
        ra[0] = v.r0; ra[1] = v.r1; ra[2] = v.r2;
        wa[0] = v.wa0; wa[1] = v.wa1;
        wd[0] = v.wd0; wd[1] = v.wd1;
        x.name = v.name;
        x.chk_nz = 1'b0;
        x.enz1 = '0;
        for (int p = 0; p < 3; p++) begin
            if (mzero(ra[p])) begin
                x.e[p] = '0;
                x.erdy[p] = 1'b1;
            end else begin
                x.e[p] = mregs[ra[p]];
                x.erdy[p] = !mbusy[ra[p]];
                for (int w = 0; w < 2; w++) begin
                    if (v.wen[w] && wa[w] == ra[p]) begin
                        x.e[p] = wd[w];
                        x.erdy[p] = 1'b1;
                    end
                end
            end
        end
        x.eok = mzero(v.ra) || !mbusy[v.ra];
        cnt = 0;
        for (int i = 0; i < 64; i++) cnt += int'(mbusy[i]);
        x.ecnt = 7'(cnt);
        @(posedge clk);
        #1;
        drive(v);
        expq.push_back(x);
        #3;
        check_outputs();
        for (int w = 0; w < 2; w++) begin
            if (v.wen[w] && !mzero(wa[w])) begin
                mregs[wa[w]] = wd[w];
                mbusy[wa[w]] = 1'b0;
            end
        end
        if (v.ren && x.eok && !v.fl && !mzero(v.ra)) mbusy[v.ra] = 1'b1;
        if (v.fl) begin
            for (int i = 0; i < 64; i++) mbusy[i] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; wb_en = '0; wb_addr = '0; wb_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0; rd_addr = '0;
        @(posedge clk);
        @(posedge clk);

        tbl.push_back(mk("wr_x5", 0, 2'b01, 5, 32'hDEAD, 0, 0, 0, 0, 0,
                         5, 5, 0, 32'hDEAD, 32'hDEAD, 0, 3'b111, 1, 0, 32'hDEAD));
        tbl.push_back(mk("rst_cyc", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                         5, 5, 0, 32'hDEAD, 32'hDEAD, 0, 3'b111, 1, 0, 32'hDEAD));
        tbl.push_back(mk("after_rst", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                         5, 5, 0, 0, 0, 0, 3'b111, 1, 0, 0));
        tbl.push_back(mk("wr_zero", 0, 2'b11, 0, 32'h1234, 32, 32'h55, 0, 0, 0,
                         0, 32, 0, 0, 0, 0, 3'b111, 1, 0, 32'h55));
        tbl.push_back(mk("rd_zero", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                         0, 32, 0, 0, 0, 0, 3'b111, 1, 0, 32'h55));
        tbl.push_back(mk("rsv_x7", 0, 2'b00, 0, 0, 0, 0, 1, 7, 0,
                         7, 0, 0, 0, 0, 0, 3'b111, 1, 0, 0));
        tbl.push_back(mk("x7_busy", 0, 2'b00, 0, 0, 0, 0, 0, 7, 0,
                         7, 0, 0, 0, 0, 0, 3'b110, 0, 1, 0));
        tbl.push_back(mk("x7_bypass", 0, 2'b01, 7, 32'hCAFE, 0, 0, 0, 7, 0,
                         7, 0, 0, 32'hCAFE, 0, 0, 3'b111, 0, 1, 0));
        tbl.push_back(mk("x7_released", 0, 2'b00, 0, 0, 0, 0, 0, 7, 0,
                         7, 0, 0, 32'hCAFE, 0, 0, 3'b111, 1, 0, 0));
        tbl.push_back(mk("collide_x9", 0, 2'b11, 9, 32'h1, 9, 32'h2, 0, 0, 0,
                         9, 9, 9, 32'h2, 32'h2, 32'h2, 3'b111, 1, 0, 32'h2));
        tbl.push_back(mk("x9_after", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                         9, 0, 0, 32'h2, 0, 0, 3'b111, 1, 0, 0));
        tbl.push_back(mk("f3_rel_rsv", 0, 2'b01, 35, 32'hF3, 0, 0, 1, 35, 0,
                         35, 0, 0, 32'hF3, 0, 0, 3'b111, 1, 0, 0));
        tbl.push_back(mk("f3_busy", 0, 2'b00, 0, 0, 0, 0, 0, 35, 0,
                         35, 0, 0, 32'hF3, 0, 0, 3'b110, 0, 1, 0));
        tbl.push_back(mk("rsv_x1", 0, 2'b00, 0, 0, 0, 0, 1, 1, 0,
                         35, 0, 0, 32'hF3, 0, 0, 3'b110, 1, 1, 0));
        tbl.push_back(mk("rsv_x2", 0, 2'b00, 0, 0, 0, 0, 1, 2, 0,
                         35, 0, 0, 32'hF3, 0, 0, 3'b110, 1, 2, 0));
        tbl.push_back(mk("rsv_f4", 0, 2'b00, 0, 0, 0, 0, 1, 36, 0,
                         35, 0, 0, 32'hF3, 0, 0, 3'b110, 1, 3, 0));
        tbl.push_back(mk("flush_wb", 0, 2'b01, 3, 32'h77, 0, 0, 1, 10, 1,
                         1, 3, 36, 0, 32'h77, 0, 3'b010, 1, 4, 32'h77));
        tbl.push_back(mk("post_flush", 0, 2'b00, 0, 0, 0, 0, 0, 10, 0,
                         1, 3, 10, 0, 32'h77, 0, 3'b111, 1, 0, 32'h77));
        tbl.push_back(mk("state_hold", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                         35, 9, 7, 32'hF3, 32'h2, 32'hCAFE, 3'b111, 1, 0, 32'h2));

        foreach (tbl[i]) apply_vec(tbl[i]);

        for (int i = 0; i < 64; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
        mregs[3]  = 32'h77;
        mregs[7]  = 32'hCAFE;
        mregs[9]  = 32'h2;
        mregs[35] = 32'hF3;

        for (int n = 0; n < 300; n++) rand_cycle(n);

        @(posedge clk);
        #1;
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL queue: %0d expectations left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
